// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: IF/ID pipeline register controller.
//   Captures the fetched instruction and PC behind a valid/ready handshake,
//   classifies its encoding format, detects load-use hazards against EX
//   (stall fetch, bubble EX), applies branch flushes and keeps saturating
//   stall / flush performance counters.
//
// Ports:
//   clk_i, rst_i                 clock, async active-low reset
//   if_valid_i/if_insr_i/if_pc_i fetch stage instruction and PC
//   if_ready_o                   ID accepts the fetch this cycle
//   id_valid_o/id_insr_o/id_pc_o registered instruction and PC
//   id_fmt_o                     registered format 0=R 1=I 2=S 3=B 4=U 5=J
//   id_ready_i                   EX accepts the ID instruction
//   ex_memread_i, ex_rd_i        load in EX and its destination register
//   flush_i                      taken branch / jump, kills ID and fetch
//   stall_o, bubble_o            load-use hazard active / EX takes a NOP
//   cnt_clr_i                    synchronous clear of both counters
//   stall_cnt_o, flush_cnt_o     saturating performance counters
module id_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             if_valid_i,
   input  logic [31:0]      if_insr_i,
   input  logic [31:0]      if_pc_i,
   output logic             if_ready_o,
   output logic             id_valid_o,
   output logic [31:0]      id_insr_o,
   output logic [31:0]      id_pc_o,
   output logic [2:0]       id_fmt_o,
   input  logic             id_ready_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             bubble_o,
   input  logic             cnt_clr_i,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [2:0] fmt_nxt;
   logic       use_rs1;
   logic       use_rs2;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       hazard;
   logic       advance;

   // Decoded from opcode bits only; order matters, first match wins.
   always_comb begin
      fmt_nxt = FMT_R;
      if (if_insr_i[4:2] == 3'b101)
         fmt_nxt = FMT_U;
      else if (if_insr_i[3:2] == 2'b11)
         fmt_nxt = FMT_J;
      else if ((if_insr_i[4:2] == 3'b001) ||
               ({if_insr_i[6:5], if_insr_i[3:2]} == 4'b0000))
         fmt_nxt = FMT_I;
      else if (if_insr_i[6:2] == 5'b01000)
         fmt_nxt = FMT_S;
      else if (if_insr_i[6:2] == 5'b11000)
         fmt_nxt = FMT_B;
   end

   assign rs1     = id_insr_o[19:15];
   assign rs2     = id_insr_o[24:20];
   assign use_rs1 = (id_fmt_o == FMT_R) || (id_fmt_o == FMT_I) ||
                    (id_fmt_o == FMT_S) || (id_fmt_o == FMT_B);
   assign use_rs2 = (id_fmt_o == FMT_R) || (id_fmt_o == FMT_S) ||
                    (id_fmt_o == FMT_B);

   assign hazard = id_valid_o && ex_memread_i && (ex_rd_i != 5'd0) &&
                   ((use_rs1 && (ex_rd_i == rs1)) ||
                    (use_rs2 && (ex_rd_i == rs2)));

   assign stall_o    = hazard && !flush_i;
   assign bubble_o   = stall_o;
   // A hazard holds ID even when EX is ready: the bubble goes to EX instead.
   assign advance    = !hazard && (id_ready_i || !id_valid_o);
   assign if_ready_o = advance || flush_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         id_valid_o <= 1'b0;
         id_insr_o  <= '0;
         id_pc_o    <= '0;
         id_fmt_o   <= FMT_R;
      end else if (flush_i) begin
         // Fetch is accepted and dropped; payload fields hold.
         id_valid_o <= 1'b0;
      end else if (advance) begin
         id_valid_o <= if_valid_i;
         if (if_valid_i) begin
            id_insr_o <= if_insr_i;
            id_pc_o   <= if_pc_i;
            id_fmt_o  <= fmt_nxt;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else if (cnt_clr_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (stall_o && (stall_cnt_o != CNT_MAX))
            stall_cnt_o <= stall_cnt_o + 1'b1;
         if (flush_i && id_valid_o && (flush_cnt_o != CNT_MAX))
            flush_cnt_o <= flush_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             if_valid_i;
   logic [31:0]      if_insr_i;
   logic [31:0]      if_pc_i;
   logic             if_ready_o;
   logic             id_valid_o;
   logic [31:0]      id_insr_o;
   logic [31:0]      id_pc_o;
   logic [2:0]       id_fmt_o;
   logic             id_ready_i;
   logic             ex_memread_i;
   logic [4:0]       ex_rd_i;
   logic             flush_i;
   logic             stall_o;
   logic             bubble_o;
   logic             cnt_clr_i;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   always #5 clk_i = ~clk_i;

   id_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_valid_i(if_valid_i), .if_insr_i(if_insr_i), .if_pc_i(if_pc_i),
      .if_ready_o(if_ready_o),
      .id_valid_o(id_valid_o), .id_insr_o(id_insr_o), .id_pc_o(id_pc_o),
      .id_fmt_o(id_fmt_o), .id_ready_i(id_ready_i),
      .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .flush_i(flush_i),
      .stall_o(stall_o), .bubble_o(bubble_o), .cnt_clr_i(cnt_clr_i),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   bit          m_valid;
   logic [31:0] m_insr;
   logic [31:0] m_pc;
   int          m_fmt;
   int          m_scnt;
   int          m_fcnt;

   // Format rules as a priority list of (opcode mask, match value, format).
   logic [6:0] cls_mask [6] = '{7'h1C, 7'h0C, 7'h1C, 7'h6C, 7'h7C, 7'h7C};
   logic [6:0] cls_val  [6] = '{7'h14, 7'h0C, 7'h04, 7'h00, 7'h20, 7'h60};
   int         cls_fmt  [6] = '{4, 5, 1, 1, 2, 3};

   logic [31:0] fmt_insr [6] = '{32'h00A00093, 32'h00112023, 32'h00208463,
                                 32'h000012B7, 32'h008000EF, 32'h002081B3};
   int          fmt_exp  [6] = '{1, 2, 3, 4, 5, 0};
   int          sat_exp  [5] = '{1, 2, 3, 3, 3};
   logic [6:0]  opc_list [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                 7'h37, 7'h6F, 7'h67};

   function automatic int classify(logic [31:0] w);
      for (int i = 0; i < 6; i++)
         if ((w[6:0] & cls_mask[i]) == cls_val[i]) return cls_fmt[i];
      return 0;
   endfunction

   function automatic bit model_hazard();
      bit r1 = (m_fmt == 0) || (m_fmt == 1) || (m_fmt == 2) || (m_fmt == 3);
      bit r2 = (m_fmt == 0) || (m_fmt == 2) || (m_fmt == 3);
      if (!m_valid || !ex_memread_i || ex_rd_i == 5'd0) return 1'b0;
      return (r1 && ex_rd_i == m_insr[19:15]) || (r2 && ex_rd_i == m_insr[24:20]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_insr = '0; m_pc = '0; m_fmt = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic drive(input bit v, input logic [31:0] insr, input logic [31:0] pc,
                        input bit rdy, input bit mr, input logic [4:0] rd,
                        input bit fl, input bit clr);
      if_valid_i = v; if_insr_i = insr; if_pc_i = pc; id_ready_i = rdy;
      ex_memread_i = mr; ex_rd_i = rd; flush_i = fl; cnt_clr_i = clr;
   endtask

   // One clock: check all outputs mid-cycle against the model, then advance it.
   task automatic cycle();
      bit hz, st, adv;
      @(negedge clk_i);
      hz  = model_hazard();
      st  = hz && !flush_i;
      adv = !hz && (id_ready_i || !m_valid);
      chk("if_ready", 32'(if_ready_o), 32'(adv || flush_i));
      chk("stall",    32'(stall_o),    32'(st));
      chk("bubble",   32'(bubble_o),   32'(st));
      chk("id_valid", 32'(id_valid_o), 32'(m_valid));
      chk("id_insr",  id_insr_o,       m_insr);
      chk("id_pc",    id_pc_o,         m_pc);
      chk("id_fmt",   32'(id_fmt_o),   32'(m_fmt));
      chk("stall_cnt", 32'(stall_cnt_o), 32'(m_scnt));
      chk("flush_cnt", 32'(flush_cnt_o), 32'(m_fcnt));
      if (cnt_clr_i) begin
         m_scnt = 0; m_fcnt = 0;
      end else begin
         if (st && m_scnt < CMAX) m_scnt++;
         if (flush_i && m_valid && m_fcnt < CMAX) m_fcnt++;
      end
      if (flush_i) m_valid = 0;
      else if (adv) begin
         m_valid = if_valid_i;
         if (if_valid_i) begin
            m_insr = if_insr_i; m_pc = if_pc_i; m_fmt = classify(if_insr_i);
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [31:0] ri;
      rst_i = 1'b0;
      drive(0, '0, '0, 1, 0, 5'd0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_valid", 32'(id_valid_o), 32'd0);
      rst_i = 1'b1;

      // Format stream at full throughput
      for (int i = 0; i < 6; i++) begin
         drive(1, fmt_insr[i], 32'h100 + 32'(4 * i), 1, 0, 5'd0, 0, 0);
         cycle();
         chk("fmt_seq", 32'(id_fmt_o), 32'(fmt_exp[i]));
      end

      // Load-use on rs2 of add x3,x1,x2
      drive(1, 32'h00000013, 32'h200, 1, 1, 5'd2, 0, 0);
      cycle();
      chk("lu_held", id_insr_o, 32'h002081B3);
      chk("lu_cnt", 32'(stall_cnt_o), 32'd1);
      drive(1, 32'h00000013, 32'h200, 1, 0, 5'd0, 0, 0);
      cycle();
      chk("lu_release", id_insr_o, 32'h00000013);

      // lui x5 in ID: no register use
      drive(1, 32'h000052B7, 32'h204, 1, 0, 5'd0, 0, 0);
      cycle();
      drive(1, 32'h002081B3, 32'h208, 1, 1, 5'd5, 0, 0);
      cycle();
      chk("lui_nostall_cnt", 32'(stall_cnt_o), 32'd1);

      // add x0,x0,x2 in ID with load to x0: no stall
      drive(1, 32'h00200033, 32'h20C, 1, 0, 5'd0, 0, 0);
      cycle();
      drive(1, 32'h002081B3, 32'h210, 1, 1, 5'd0, 0, 0);
      cycle();

      // Flush during hazard (ID holds add x3,x1,x2 from above)
      drive(1, 32'h00000013, 32'h214, 1, 1, 5'd1, 1, 0);
      cycle();
      chk("flush_valid", 32'(id_valid_o), 32'd0);
      chk("flush_cnt1", 32'(flush_cnt_o), 32'd1);
      chk("flush_scnt", 32'(stall_cnt_o), 32'd1);

      // Backpressure
      drive(1, 32'h002081B3, 32'h300, 1, 0, 5'd0, 0, 0);
      cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h00A00093, 32'h304, 0, 0, 5'd0, 0, 0);
         cycle();
         chk("bp_hold", id_pc_o, 32'h300);
      end
      drive(1, 32'h00A00093, 32'h304, 1, 0, 5'd0, 0, 0);
      cycle();
      chk("bp_load", id_pc_o, 32'h304);
      drive(1, 32'h00112023, 32'h308, 1, 0, 5'd0, 0, 0);
      cycle();
      chk("bp_next", id_pc_o, 32'h308);

      // Saturation with CNT_W=2
      drive(1, 32'h002081B3, 32'h400, 1, 0, 5'd0, 0, 1);
      cycle();
      for (int i = 0; i < 5; i++) begin
         drive(1, 32'h00000013, 32'h404, 1, 1, 5'd1, 0, 0);
         cycle();
         chk("sat_seq", 32'(stall_cnt_o), 32'(sat_exp[i]));
      end
      drive(1, 32'h00000013, 32'h404, 1, 1, 5'd1, 0, 1);
      cycle();
      chk("sat_clr", 32'(stall_cnt_o), 32'd0);

      // Asynchronous reset mid-run while ID holds a stalled instruction
      drive(1, 32'h00000013, 32'h404, 1, 1, 5'd1, 0, 0);
      cycle();
      #2;
      rst_i = 1'b0;
      #1;
      chk("arst_valid", 32'(id_valid_o), 32'd0);
      chk("arst_insr",  id_insr_o, 32'd0);
      chk("arst_fmt",   32'(id_fmt_o), 32'd0);
      chk("arst_stall", 32'(stall_o), 32'd0);
      chk("arst_scnt",  32'(stall_cnt_o), 32'd0);
      chk("arst_fcnt",  32'(flush_cnt_o), 32'd0);
      model_reset();
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         ri = $urandom;
         if ($urandom_range(0, 1) == 1) ri[6:0] = opc_list[$urandom_range(0, 7)];
         ri[19:15] = 5'($urandom_range(0, 3));
         ri[24:20] = 5'($urandom_range(0, 3));
         drive(1'($urandom_range(0, 3) != 0), ri, $urandom,
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 15) == 0));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- IF/ID pipeline-register controller for the pipelined RISC-V core.
- Captures fetched instruction and PC behind a valid/ready handshake and classifies the instruction format for the immediate generator's select path.
- Detects load-use hazards against EX, stalls fetch and requests an EX bubble, and applies branch flushes.
- Keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of each performance counter (min 2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-low
if_valid_i  in  1  fetch stage presents an instruction
if_insr_i  in  32  fetched instruction
if_pc_i  in  32  PC of fetched instruction
if_ready_o  out  1  ID register accepts the fetch this cycle
id_valid_o  out  1  ID register holds a live instruction
id_insr_o  out  32  registered instruction
id_pc_o  out  32  registered PC
id_fmt_o  out  3  registered format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J
id_ready_i  in  1  EX accepts the ID instruction this cycle
ex_memread_i  in  1  instruction in EX is a load
ex_rd_i  in  5  destination register of instruction in EX
flush_i  in  1  taken branch / jump; kill ID and the current fetch
stall_o  out  1  load-use hazard active
bubble_o  out  1  EX must take a NOP this cycle
cnt_clr_i  in  1  synchronous clear of both counters
stall_cnt_o  out  CNT_W  saturating stall-cycle count
flush_cnt_o  out  CNT_W  saturating killed-instruction count

Behaviour:
- Reset (rst_i=0, immediate, asynchronous):
  - id_valid_o=0, id_insr_o=0, id_pc_o=0, id_fmt_o=0.
  - Both counters = 0.
- Format classification is combinational on if_insr_i, first match wins:
  - U if [4:2]=101
  - J if [3:2]=11
  - I if [4:2]=001 or {[6:5],[3:2]}=0000
  - S if [6:2]=01000
  - B if [6:2]=11000
  - else R
  - The result is registered with the instruction.
- Register usage follows the registered format:
  - rs1 used by R, I, S, B.
  - rs2 used by R, S, B.
  - U and J use neither.
  - rs1 = id_insr_o[19:15], rs2 = id_insr_o[24:20].
- hazard (combinational) = id_valid_o & ex_memread_i & (ex_rd_i != 0) & ((use_rs1 & ex_rd_i==rs1) | (use_rs2 & ex_rd_i==rs2)).
- stall_o = hazard & ~flush_i.
- bubble_o = stall_o.
- advance = ~hazard & (id_ready_i | ~id_valid_o).
- if_ready_o = advance | flush_i.
- Register update per edge, in priority order:
  1. flush_i=1: id_valid_o<=0. Fetch is accepted and discarded. Insr/PC/fmt are don't-care but hold.
  2. advance=1: id_valid_o<=if_valid_i. Insr, PC and fmt load only when if_valid_i=1.
  3. Otherwise hold all fields.
- Latency:
  - IF to ID is 1 cycle.
  - A load-use stall lasts exactly 1 cycle, since EX takes the bubble and ex_memread_i drops.
  - Back-to-back transfers sustain 1 instruction per cycle.
- Counters:
  - cnt_clr_i=1 forces both to 0; clear wins over increment in the same cycle.
  - stall_cnt_o +1 on each cycle with stall_o=1.
  - flush_cnt_o +1 on each cycle with flush_i=1 and id_valid_o=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Simultaneous events:
  - Flush overrides hazard and backpressure.
  - A hazard with id_ready_i=1 still holds the instruction in ID.
- Reset mid-stall or mid-transfer drops the held instruction. No handshake completes during reset.

Test Plan:
- Reset check: assert rst_i=0 mid-run with id_valid_o=1 -> id_valid_o, id_insr_o, id_fmt_o, stall_o and both counters read 0 immediately, before any clock edge.
- Format stream, id_ready_i=1: feed 0x00A00093 (addi), 0x00112023 (sw), 0x00208463 (beq), 0x000012B7 (lui), 0x008000EF (jal), 0x002081B3 (add) -> id_fmt_o 1,2,3,4,5,0 on consecutive cycles, 1-cycle latency, if_ready_o stays 1.
- Load-use:
  - ID holds add x3,x1,x2 and EX has ex_memread_i=1, ex_rd_i=2 -> stall_o=1, bubble_o=1, if_ready_o=0 for 1 cycle, ID held, stall_cnt_o=1.
  - Same with ID holding lui x5 -> no stall.
  - Same with ex_rd_i=0 -> no stall.
- Flush during hazard: hazard active and flush_i=1 -> stall_o=0, if_ready_o=1, next cycle id_valid_o=0, flush_cnt_o +1, stall_cnt_o unchanged.
- Backpressure: id_valid_o=1, id_ready_i=0 for 3 cycles with if_valid_i=1 -> if_ready_o=0, ID fields stable. Release -> the next fetch loads the following cycle with no loss or duplication.
- Counter saturation, CNT_W=2: 5 consecutive stall cycles -> stall_cnt_o 1,2,3,3,3. Then cnt_clr_i together with stall_o=1 -> 0.
